// File: rtl/unidade_controle_rodadas_pkg.sv
// Shared definitions for the round-based memory-game controller: state codes
// (also shown on the hexa7seg display), default timing and the Moore output decoder.
package unidade_controle_rodadas_pkg;

  localparam int TIMEOUT_CICLOS_PADRAO = 5000;
  localparam int TW_PADRAO             = 13;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_RODADA = 4'h6,
    PROXIMA_JOGADA = 4'h7,
    FIM_ACERTOU    = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERROU      = 4'hE
  } estado_t;

  typedef struct packed {
    logic zera_e;
    logic conta_e;
    logic zera_l;
    logic conta_l;
    logic zera_r;
    logic registra_r;
    logic acertou;
    logic errou;
    logic pronto;
    logic timeout;
  } saidas_t;

  function automatic saidas_t decodifica_saidas(estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARACAO: begin
        s.zera_e = 1'b1;
        s.zera_l = 1'b1;
        s.zera_r = 1'b1;
      end
      INICIO_RODADA:  s.zera_e     = 1'b1;
      REGISTRA:       s.registra_r = 1'b1;
      PROXIMA_RODADA: s.conta_l    = 1'b1;
      PROXIMA_JOGADA: s.conta_e    = 1'b1;
      FIM_ACERTOU: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      FIM_ERROU: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto  = 1'b1;
        s.errou   = 1'b1;
        s.timeout = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_rodadas_if.sv
// Control/status bundle between the round controller and the memory-game datapath.
interface unidade_controle_rodadas_if;

  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fim_rodada;
  logic       fim_jogo;

  logic       zeraE;
  logic       contaE;
  logic       zeraL;
  logic       contaL;
  logic       zeraR;
  logic       registraR;
  logic       acertou;
  logic       errou;
  logic       pronto;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    output iniciar, jogada, igual, fim_rodada, fim_jogo,
    input  zeraE, contaE, zeraL, contaL, zeraR, registraR,
           acertou, errou, pronto, timeout, db_estado
  );

  modport slave (
    input  iniciar, jogada, igual, fim_rodada, fim_jogo,
    output zeraE, contaE, zeraL, contaL, zeraR, registraR,
           acertou, errou, pronto, timeout, db_estado
  );

endinterface

// File: rtl/unidade_controle_rodadas_contador_timeout.sv
// Per-jogada timeout counter: counts while enabled, flags fim at TIMEOUT_CICLOS-1.
module unidade_controle_rodadas_contador_timeout
  import unidade_controle_rodadas_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
  parameter int TW             = TW_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  logic [TW-1:0] contagem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= '0;
    end else if (conta) begin
      contagem <= contagem + TW'(1);
    end
  end

  assign fim = (contagem == TW'(TIMEOUT_CICLOS - 1));

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Moore control unit sequencing the memory-game rounds: jogada/round counters,
// jogada register, comparator verdict and per-jogada timeout.
module unidade_controle_rodadas
  import unidade_controle_rodadas_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
  parameter int TW             = TW_PADRAO
) (
  input logic                     clock,
  input logic                     reset,
  unidade_controle_rodadas_if.slave bus
);

  estado_t estado;
  estado_t proximo;
  saidas_t saidas;
  logic    fim_timer;
  logic    zera_timer;
  logic    conta_timer;

  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:        proximo = bus.iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     proximo = INICIO_RODADA;
      INICIO_RODADA:  proximo = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (bus.jogada)     proximo = REGISTRA;
        else if (fim_timer) proximo = FIM_TIMEOUT;
        else                proximo = ESPERA_JOGADA;
      end
      REGISTRA:       proximo = COMPARACAO;
      COMPARACAO: begin
        if (!bus.igual)                       proximo = FIM_ERROU;
        else if (bus.fim_rodada && bus.fim_jogo) proximo = FIM_ACERTOU;
        else if (bus.fim_rodada)              proximo = PROXIMA_RODADA;
        else                                  proximo = PROXIMA_JOGADA;
      end
      PROXIMA_RODADA: proximo = INICIO_RODADA;
      PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
      FIM_ACERTOU,
      FIM_ERROU,
      FIM_TIMEOUT:    proximo = bus.iniciar ? PREPARACAO : estado;
      default:        proximo = INICIAL;
    endcase
  end

  // Timer is held at zero outside espera_jogada and on the edge leaving it,
  // so every new wait starts from 0 and the count never passes TIMEOUT_CICLOS-1.
  assign zera_timer  = (estado != ESPERA_JOGADA) || (proximo != ESPERA_JOGADA);
  assign conta_timer = !zera_timer;

  unidade_controle_rodadas_contador_timeout #(
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
    .TW             (TW)
  ) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (zera_timer),
    .conta (conta_timer),
    .fim   (fim_timer)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
      saidas <= '0;
    end else begin
      estado <= proximo;
      saidas <= decodifica_saidas(proximo);
    end
  end

  assign bus.zeraE     = saidas.zera_e;
  assign bus.contaE    = saidas.conta_e;
  assign bus.zeraL     = saidas.zera_l;
  assign bus.contaL    = saidas.conta_l;
  assign bus.zeraR     = saidas.zera_r;
  assign bus.registraR = saidas.registra_r;
  assign bus.acertou   = saidas.acertou;
  assign bus.errou     = saidas.errou;
  assign bus.pronto    = saidas.pronto;
  assign bus.timeout   = saidas.timeout;
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Scoreboard bench for unidade_controle_rodadas: randomized games against a
// game-level outcome model, plus directed reset/restart/boundary scenarios.
module tb_unidade_controle_rodadas;

  localparam int T = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  unidade_controle_rodadas_if sinais ();

  unidade_controle_rodadas #(
    .TIMEOUT_CICLOS (T),
    .TW             (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sinais)
  );

  typedef struct {
    int codigo;
    bit acertou;
    bit errou;
    bit timeout;
    int n_reg;
    int n_ce;
    int n_cl;
    int latencia;
  } esperado_t;

  esperado_t fila[$];
  int checks = 0;
  int errors = 0;

  task automatic check_output(input string nome, input int atual, input int requerido);
    checks++;
    if (atual != requerido) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nome, atual, atual, requerido, requerido);
    end
  endtask

  function automatic int vetor_saidas();
    return int'({sinais.zeraE, sinais.contaE, sinais.zeraL, sinais.contaL, sinais.zeraR,
                 sinais.registraR, sinais.acertou, sinais.errou, sinais.pronto, sinais.timeout});
  endfunction

  // Monitor: counts datapath pulses per game and scores each game when pronto rises.
  int         ciclo      = 0;
  bit         jog_esp    = 1'b0;
  logic [3:0] estado_neg = 4'h0;
  logic       pronto_ant = 1'b0;
  int         n_reg = 0, n_ce = 0, n_cl = 0, ult_reg = 0, ult_espera = 0;

  always @(posedge clock) begin
    jog_esp = (sinais.jogada === 1'b1) && (estado_neg == 4'h3);
    ciclo++;
  end

  always @(negedge clock) begin
    esperado_t e;
    if (sinais.registraR || jog_esp)
      check_output("registraR_apos_jogada", int'(sinais.registraR), int'(jog_esp));
    if (sinais.zeraL) begin
      n_reg = 0;
      n_ce  = 0;
      n_cl  = 0;
    end
    if (sinais.registraR) begin
      n_reg++;
      ult_reg = ciclo;
    end
    if (sinais.contaE) n_ce++;
    if (sinais.contaL) n_cl++;
    if (sinais.db_estado == 4'h3 && estado_neg != 4'h3) ult_espera = ciclo;
    if (sinais.pronto && !pronto_ant) begin
      if (fila.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pronto_inesperado: pronto rose in state 0x%0h with no game expected", sinais.db_estado);
      end else begin
        e = fila.pop_front();
        check_output("estado_final", int'(sinais.db_estado), e.codigo);
        check_output("acertou", int'(sinais.acertou), int'(e.acertou));
        check_output("errou", int'(sinais.errou), int'(e.errou));
        check_output("timeout", int'(sinais.timeout), int'(e.timeout));
        check_output("n_registraR", n_reg, e.n_reg);
        check_output("n_contaE", n_ce, e.n_ce);
        check_output("n_contaL", n_cl, e.n_cl);
        check_output("latencia", e.timeout ? ciclo - ult_espera : ciclo - ult_reg, e.latencia);
      end
    end
    pronto_ant = sinais.pronto;
    estado_neg = sinais.db_estado;
  end

  task automatic esperar_estado(input logic [3:0] codigo, input int limite, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limite; i++) begin
      @(negedge clock);
      if (sinais.db_estado == codigo) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL espera_estado: state 0x%0h, expected 0x%0h within %0d cycles", sinais.db_estado, codigo, limite);
    end
  endtask

  task automatic esperar_pronto(input int limite, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limite; i++) begin
      @(negedge clock);
      if (sinais.pronto) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL espera_pronto: pronto=%0d in state 0x%0h, expected 1 within %0d cycles", sinais.pronto, sinais.db_estado, limite);
    end
  endtask

  // tipo: 0 = play to the end, 1 = wrong jogada at step parada, 2 = no jogada at step parada.
  task automatic apply_stimulus(input int n_rodadas, input int parada, input int tipo, input int atraso_fixo);
    int        atrasos[$];
    esperado_t e;
    int        total;
    int        passo;
    bit        fim;
    bit        ok;
    bit        certo;
    total = n_rodadas * (n_rodadas + 1) / 2;
    for (int i = 0; i < total; i++)
      atrasos.push_back(atraso_fixo >= 0 ? atraso_fixo : int'($urandom_range(0, 3)));
    if (tipo == 2) atrasos[parada] = T + int'($urandom_range(0, 2));

    e.codigo = 4'hA; e.acertou = 1'b0; e.errou = 1'b0; e.timeout = 1'b0;
    e.n_reg = 0; e.n_ce = 0; e.n_cl = 0; e.latencia = 2;
    passo = 0;
    fim   = 1'b0;
    for (int r = 0; r < n_rodadas; r++) begin
      for (int j = 0; j <= r; j++) begin
        if (!fim) begin
          if (atrasos[passo] >= T) begin
            e.codigo = 4'hD; e.errou = 1'b1; e.timeout = 1'b1; e.latencia = T;
            fim = 1'b1;
          end else begin
            e.n_reg++;
            if (tipo == 1 && passo == parada) begin
              e.codigo = 4'hE; e.errou = 1'b1;
              fim = 1'b1;
            end else if (j == r) begin
              if (r == n_rodadas - 1) begin
                e.acertou = 1'b1;
                fim = 1'b1;
              end else begin
                e.n_cl++;
              end
            end else begin
              e.n_ce++;
            end
          end
          passo++;
        end
      end
    end
    fila.push_back(e);

    @(negedge clock);
    sinais.iniciar = 1'b1;
    @(negedge clock);
    sinais.iniciar = 1'b0;
    passo = 0;
    fim   = 1'b0;
    ok    = 1'b1;
    for (int r = 0; r < n_rodadas; r++) begin
      for (int j = 0; j <= r; j++) begin
        if (!fim && ok) begin
          esperar_estado(4'h3, 20, ok);
          if (ok) begin
            certo = !(tipo == 1 && passo == parada);
            sinais.igual      = certo;
            sinais.fim_rodada = (j == r);
            sinais.fim_jogo   = (r == n_rodadas - 1);
            if (atrasos[passo] >= T) begin
              fim = 1'b1;
            end else begin
              repeat (atrasos[passo]) @(negedge clock);
              sinais.jogada = 1'b1;
              @(negedge clock);
              sinais.jogada = 1'b0;
              if (!certo) fim = 1'b1;
            end
          end
          passo++;
        end
      end
    end
    if (ok) esperar_pronto(T + 10, ok);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    esperado_t e;
    bit        ok;
    int        n, tipo, total, parada, fixo;

    sinais.iniciar    = 1'b0;
    sinais.jogada     = 1'b0;
    sinais.igual      = 1'b0;
    sinais.fim_rodada = 1'b0;
    sinais.fim_jogo   = 1'b0;

    #2 reset = 1'b0;
    #10;
    check_output("reset_db_estado", int'(sinais.db_estado), 0);
    check_output("reset_saidas", vetor_saidas(), 0);
    @(negedge clock);
    check_output("reset_mantido_db_estado", int'(sinais.db_estado), 0);
    reset = 1'b1;
    @(negedge clock);
    check_output("inicial_sem_iniciar", int'(sinais.db_estado), 0);

    // Two-round win with immediate jogadas.
    apply_stimulus(2, 0, 0, 0);
    // Mismatch on the very first jogada, with fim_rodada and fim_jogo also high.
    apply_stimulus(1, 0, 1, 1);

    // Restart from fim_errou.
    @(negedge clock);
    sinais.iniciar = 1'b1;
    @(negedge clock);
    check_output("restart_db_estado", int'(sinais.db_estado), 1);
    check_output("restart_zeras", int'({sinais.zeraE, sinais.zeraL, sinais.zeraR}), 7);
    check_output("restart_errou", int'(sinais.errou), 0);
    check_output("restart_pronto", int'(sinais.pronto), 0);
    sinais.iniciar = 1'b0;
    @(negedge clock);
    check_output("restart_seguinte_db_estado", int'(sinais.db_estado), 2);
    check_output("restart_zeraL_zeraR_um_ciclo", int'({sinais.zeraL, sinais.zeraR}), 0);

    // Asynchronous reset in comparacao.
    esperar_estado(4'h3, 20, ok);
    sinais.igual      = 1'b1;
    sinais.fim_rodada = 1'b0;
    sinais.fim_jogo   = 1'b0;
    sinais.jogada     = 1'b1;
    @(negedge clock);
    sinais.jogada = 1'b0;
    @(negedge clock);
    check_output("pre_reset_db_estado", int'(sinais.db_estado), 5);
    #2 reset = 1'b0;
    #1;
    check_output("reset_async_db_estado", int'(sinais.db_estado), 0);
    check_output("reset_async_saidas", vetor_saidas(), 0);
    @(negedge clock);
    reset = 1'b1;
    sinais.iniciar = 1'b1;
    e.codigo = 4'hD; e.acertou = 1'b0; e.errou = 1'b1; e.timeout = 1'b1;
    e.n_reg = 0; e.n_ce = 0; e.n_cl = 0; e.latencia = T;
    fila.push_back(e);
    @(negedge clock);
    check_output("pos_reset_db_estado", int'(sinais.db_estado), 1);
    sinais.iniciar = 1'b0;
    esperar_pronto(T + 20, ok);

    // Timeout on the first jogada, then every jogada exactly at the last timer cycle.
    apply_stimulus(2, 0, 2, 0);
    apply_stimulus(3, 0, 0, T - 1);

    for (int g = 0; g < 30; g++) begin
      n      = int'($urandom_range(1, 4));
      tipo   = int'($urandom_range(0, 2));
      total  = n * (n + 1) / 2;
      parada = int'($urandom_range(0, total - 1));
      fixo   = (g % 4 == 0) ? T - 1 : -1;
      apply_stimulus(n, parada, tipo, fixo);
    end

    repeat (3) @(negedge clock);
    check_output("fila_final", fila.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_controle_rodadas.md
Name: unidade_controle_rodadas

Overview:
- Moore control unit that sequences the memory-game datapath: jogada counter, round-limit counter, jogada register, memory and comparator.
- Game runs in rounds. In round r the player repeats memory positions 0..r. Each jogada must arrive within a timeout window.
- Ends in acertou (all rounds correct), errou (mismatch) or timeout. Replaces the single-pass controller in the next game top-level.

Parameters:
- TIMEOUT_CICLOS, 5000, clock cycles allowed per jogada while waiting (5 s at 1 kHz); minimum 2.
- TW, 13, width of the internal timeout counter; must satisfy 2^TW > TIMEOUT_CICLOS.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- iniciar  in  1  start/restart request, level-sampled.
- jogada  in  1  one-cycle pulse from the datapath edge detector (jogada_feita).
- igual  in  1  comparator: registered jogada == memory word.
- fim_rodada  in  1  jogada address == current round limit.
- fim_jogo  in  1  round counter at last round.
- zeraE  out  1  clear jogada/address counter.
- contaE  out  1  increment jogada/address counter.
- zeraL  out  1  clear round-limit counter.
- contaL  out  1  increment round-limit counter.
- zeraR  out  1  clear jogada register.
- registraR  out  1  load jogada register.
- acertou  out  1  game won.
- errou  out  1  game lost (mismatch or timeout).
- pronto  out  1  game finished.
- timeout  out  1  loss caused by timeout.
- db_estado  out  4  current state code, for the hexa7seg display.

Behaviour:
- Reset: async on reset=0. State goes to inicial and all outputs are 0, including db_estado=0x0 and the timer=0. Reset mid-game aborts immediately, with no terminal flags.
- All outputs are Moore, decoded from state only. db_estado equals the state code.
- States, codes and transitions:
  - inicial 0x0: no outputs asserted. Goes to preparacao when iniciar=1.
  - preparacao 0x1: asserts zeraE, zeraL, zeraR. Goes to inicio_rodada.
  - inicio_rodada 0x2: asserts zeraE. Goes to espera_jogada.
  - espera_jogada 0x3: timer counts. Goes to registra on jogada=1. Otherwise goes to fim_timeout when timer==TIMEOUT_CICLOS-1. Otherwise stays.
  - registra 0x4: asserts registraR. Goes to comparacao.
  - comparacao 0x5, in priority order:
    - igual=0 → fim_errou.
    - fim_rodada & fim_jogo → fim_acertou.
    - fim_rodada → proxima_rodada.
    - otherwise → proxima_jogada.
  - proxima_rodada 0x6: asserts contaL. Goes to inicio_rodada.
  - proxima_jogada 0x7: asserts contaE. Goes to espera_jogada.
  - fim_acertou 0xA: asserts pronto, acertou.
  - fim_errou 0xE: asserts pronto, errou.
  - fim_timeout 0xD: asserts pronto, errou, timeout.
  - Each terminal state holds until iniciar=1, then goes to preparacao. acertou and errou are never both 1.
- Unused codes (0x8, 0x9, 0xB, 0xC, 0xF) go to inicial on the next edge.
- Timer:
  - Zeroed in every state except espera_jogada.
  - Increments by 1 per cycle in espera_jogada. Zeroed on entry, so each jogada gets a fresh window.
  - Never wraps: leaves espera_jogada at TIMEOUT_CICLOS-1 at the latest.
- jogada and timeout in the same cycle: jogada wins, so no timeout is taken.
- iniciar outside inicial and the terminal states is ignored.
- jogada pulses outside espera_jogada are ignored.
- Latency:
  - iniciar sampled in inicial → zeraE/zeraL/zeraR high for one cycle on the next cycle.
  - jogada pulse → registraR next cycle → verdict (pronto, or contaE/contaL) 2 cycles after registraR.
- Round r (0-based) needs r+1 correct jogadas.

Decomposition:
- Shared package or include: the 4-bit state code constants (shared with the display decoder and benches), plus the default TIMEOUT_CICLOS.
- One natural sub-module: contador_timeout. Inputs: clock, reset, zera, conta. Output: fim at TIMEOUT_CICLOS-1. Parameterised by TIMEOUT_CICLOS and TW.

Test Plan:
- Win, 2-round game (fim_jogo high on round 1), TIMEOUT_CICLOS=10: iniciar, then correct jogadas 1, 2 → states 0,1,2,3,4,5,6,2,3,4,5,7,3,4,5,A. Ends acertou=1, pronto=1, errou=0, db_estado=0xA.
- Mismatch: round 0, igual=0 at comparacao → next state 0xE with errou=1, pronto=1, timeout=0. No contaE/contaL pulses after registraR.
- Timeout, TIMEOUT_CICLOS=10: hold in 0x3 with no jogada → 0xD exactly 10 cycles after entry. timeout=1, errou=1, pronto=1.
- Boundary: jogada asserted in the same cycle the timer hits 9 → next state 0x4, not 0xD. The next espera_jogada restarts the timer at 0.
- Async reset: pull reset low mid-cycle in state 0x5 → db_estado=0x0 and all outputs 0 before the next clock edge. After release, iniciar=1 → 0x1.
- Restart from terminal: in 0xE, iniciar=1 → 0x1 with zeraE/zeraL/zeraR=1 for exactly one cycle. errou drops to 0.
